// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - CDB arbiter widths, FU tags and age counter type
`include "define.vh"

package cdb_arbiter_pkg;

    localparam int CDB_W = `NUM_CDBBITS;
    localparam int PAY_W = `NUM_CDBBITS - 1;
    localparam int AGE_W = 4;

    localparam logic [2:0] FU_ALU_TAG = `FU_ALU;
    localparam logic [2:0] FU_MEM_TAG = `FU_MEM;
    localparam logic [2:0] FU_MUL_TAG = `FU_MUL;
    localparam logic [2:0] FU_DIV_TAG = `FU_DIV;

    typedef logic [AGE_W-1:0] age_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rtl/cdb_arbiter_rr_pick.sv - combinational one-hot round-robin selector
import cdb_arbiter_pkg::*;

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk N positions starting at the pointer; the first active request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(start) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/define.vh
// rtl/define.vh - shared CDB bus layout and functional-unit tag constants
`ifndef CDB_DEFINE_VH
`define CDB_DEFINE_VH

`define NUM_CDBBITS   40
`define CDB_ON_FIELD  39
`define CDB_FU_FIELD  38:36
`define CDB_RS_FIELD  35:32
`define CDB_VAL_FIELD 31:0

`define FU_ALU 3'd0
`define FU_MEM 3'd1
`define FU_MUL 3'd2
`define FU_DIV 3'd3

`endif

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter with round-robin and age promotion
`include "define.vh"
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AGE_MAX = 7
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*(`NUM_CDBBITS-1)-1:0] req_data,
    output logic [`NUM_CDBBITS-1:0]            cdb,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [15:0]                        conflict_cnt
);

    localparam int PW = ptr_width(NUM_REQ);

    logic [PW-1:0]              rr_ptr;
    age_t [NUM_REQ-1:0]         age_q;

    logic [NUM_REQ-1:0]         rr_grant;
    logic [NUM_REQ-1:0]         aged;
    logic [NUM_REQ-1:0]         age_grant;
    logic [NUM_REQ-1:0]         gnt_nxt;
    logic [PAY_W-1:0]           pay_nxt;
    logic [PW-1:0]              ptr_nxt;
    age_t [NUM_REQ-1:0]         age_nxt;
    logic                       any_req;
    logic                       multi_req;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req   (req),
        .start (rr_ptr),
        .grant (rr_grant)
    );

    assign any_req   = |req;
    assign multi_req = ($countones(req) >= 2);

    // A starved requester at the age limit preempts round-robin; lowest index wins ties.
    always_comb begin
        aged      = '0;
        age_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            aged[i] = req[i] && (age_q[i] == AGE_W'(AGE_MAX));
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (aged[i]) begin
                age_grant    = '0;
                age_grant[i] = 1'b1;
            end
        end
    end

    assign gnt_nxt = (|aged) ? age_grant : rr_grant;

    always_comb begin
        pay_nxt = '0;
        ptr_nxt = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_nxt[i]) begin
                pay_nxt = req_data[i*PAY_W +: PAY_W];
                ptr_nxt = PW'((i + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        age_nxt = age_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] || gnt_nxt[i]) begin
                age_nxt[i] = '0;
            end else if (age_q[i] != AGE_W'(AGE_MAX)) begin
                age_nxt[i] = age_q[i] + age_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb          <= '0;
            grant        <= '0;
            rr_ptr       <= '0;
            age_q        <= '0;
            conflict_cnt <= '0;
        end else if (flush) begin
            // Pointer and conflict statistics survive a flush; in-flight results do not.
            cdb   <= '0;
            grant <= '0;
            age_q <= '0;
        end else begin
            cdb   <= any_req ? {1'b1, pay_nxt} : '0;
            grant <= gnt_nxt;
            age_q <= age_nxt;
            if (any_req) begin
                rr_ptr <= ptr_nxt;
            end
            if (multi_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
`timescale 1ns/1ps
import cdb_arbiter_pkg::*;

module tb_cdb_arbiter;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [3:0]           req;
    logic [3:0]           req_a;
    logic                 flush_a;
    logic [4*PAY_W-1:0]   req_data;
    logic [CDB_W-1:0]     cdb;
    logic [3:0]           grant;
    logic [15:0]          conflict_cnt;
    logic [CDB_W-1:0]     cdb_a;
    logic [3:0]           grant_a;
    logic [15:0]          conflict_cnt_a;

    logic [PAY_W-1:0]     pay [4];
    int                   n_tests;
    int                   n_fail;

    cdb_arbiter #(.NUM_REQ(4), .AGE_MAX(7)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .req          (req),
        .req_data     (req_data),
        .cdb          (cdb),
        .grant        (grant),
        .conflict_cnt (conflict_cnt)
    );

    cdb_arbiter #(.NUM_REQ(4), .AGE_MAX(1)) u_dut_age (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush_a),
        .req          (req_a),
        .req_data     (req_data),
        .cdb          (cdb_a),
        .grant        (grant_a),
        .conflict_cnt (conflict_cnt_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CDB_W-1:0] on_bus(input int g);
        return {1'b1, pay[g]};
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        flush_a = 1'b0;
        req     = 4'b0000;
        req_a   = 4'b0000;
        pay[0]  = {FU_ALU_TAG, 4'b0001, 32'h0000_00A0};
        pay[1]  = {FU_MEM_TAG, 4'b0010, 32'h0000_00B1};
        pay[2]  = {FU_MUL_TAG, 4'b0100, 32'h0000_0015};
        pay[3]  = {FU_DIV_TAG, 4'b1000, 32'h0000_00D3};
        req_data = {pay[3], pay[2], pay[1], pay[0]};

        #12;
        chk("reset_cdb", 64'(cdb), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_conflict", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Aging override on the AGE_MAX=1 instance
        req_a = 4'b1001;
        step();
        chk("age_a_grant", 64'(grant_a), 64'b0001);
        chk("age_a_cdb", 64'(cdb_a), 64'(on_bus(0)));
        req_a = 4'b1011;
        step();
        chk("age_b_grant", 64'(grant_a), 64'b1000);
        chk("age_b_cdb", 64'(cdb_a), 64'(on_bus(3)));
        req_a = 4'b1111;
        step();
        chk("age_c_grant", 64'(grant_a), 64'b0001);
        req_a = 4'b0000;
        step();
        chk("age_idle_cdb", 64'(cdb_a), 64'd0);

        // Single uncontested MUL request
        req = 4'b0100;
        step();
        chk("single_cdb", 64'(cdb), 64'(on_bus(2)));
        chk("single_value", 64'(cdb[31:0]), 64'h15);
        chk("single_grant", 64'(grant), 64'b0100);
        chk("single_ptr", 64'(u_dut.rr_ptr), 64'd3);
        req = 4'b0000;
        step();
        chk("idle_cdb", 64'(cdb), 64'd0);
        chk("idle_grant", 64'(grant), 64'd0);
        chk("idle_ptr", 64'(u_dut.rr_ptr), 64'd3);

        req = 4'b1000;
        step();
        chk("wrap_grant", 64'(grant), 64'b1000);
        chk("wrap_ptr", 64'(u_dut.rr_ptr), 64'd0);

        // Full contention from pointer 0
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rr_grant_%0d", k), 64'(grant), 64'(4'b0001 << (k % 4)));
            chk($sformatf("rr_cdb_%0d", k), 64'(cdb), 64'(on_bus(k % 4)));
        end
        chk("rr_conflict", 64'(conflict_cnt), 64'd8);

        // Flush retains pointer and conflict count
        req = 4'b0011;
        step();
        chk("pre_flush_grant", 64'(grant), 64'b0001);
        chk("pre_flush_conflict", 64'(conflict_cnt), 64'd9);
        flush = 1'b1;
        step();
        chk("flush_cdb", 64'(cdb), 64'd0);
        chk("flush_grant", 64'(grant), 64'd0);
        chk("flush_ages", 64'(u_dut.age_q), 64'd0);
        chk("flush_conflict", 64'(conflict_cnt), 64'd9);
        chk("flush_ptr", 64'(u_dut.rr_ptr), 64'd1);
        flush = 1'b0;
        step();
        chk("post_flush_grant", 64'(grant), 64'b0010);
        chk("post_flush_cdb", 64'(cdb), 64'(on_bus(1)));
        chk("post_flush_conflict", 64'(conflict_cnt), 64'd10);

        // Asynchronous reset during a valid broadcast
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_cdb", 64'(cdb), 64'd0);
        chk("areset_grant", 64'(grant), 64'd0);
        chk("areset_conflict", 64'(conflict_cnt), 64'd0);
        chk("areset_ptr", 64'(u_dut.rr_ptr), 64'd0);
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_grant", 64'(grant), 64'b1000);
        chk("post_reset_cdb", 64'(cdb), 64'(on_bus(3)));
        chk("post_reset_ptr", 64'(u_dut.rr_ptr), 64'd0);

        // Conflict counter saturation
        req = 4'b0011;
        repeat (65534) step();
        chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
        step();
        chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
        repeat (5) step();
        chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
        req = 4'b0000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
